io_port_ctrl: RTL
=================

// Module: io_port_ctrl
// PURPOSE
//  Memory-mapped output port on the CPU bus alongside main memory. Snoops CPU stores
//  (MW, add_out, data_out); stores to PORT_ADDR are queued in a FIFO and presented on
//  OP one byte at a time with a valid/ready handshake to the board-level consumer.
//  Stores to any other address are ignored; memory sees all stores unchanged.
// PARAMETERS
//  PORT_ADDR    8'hFF  store address captured into the FIFO
//  STATUS_ADDR  8'hFE  status/control address (used only with STATUS_READ_EN)
//  DEPTH        8      FIFO entries; power of 2, 2..128
//  GAP_CYCLES   0      idle cycles forced after each completed handshake (0..255)
// PORTS
//  clk         in   1   system clock, rising edge
//  rst         in   1   synchronous reset, active-high
//  MW          in   1   CPU memory-write strobe
//  add_out     in   8   CPU address bus
//  data_out    in   8   CPU write data
//  OP          out  8   presented byte; holds last value when op_valid=0
//  op_valid    out  1   OP carries an unconsumed byte
//  op_ready    in   1   consumer accepts OP this cycle
//  full        out  1   FIFO count == DEPTH
//  overflow    out  1   sticky: a port store was dropped
//  status_out  out  16  (STATUS_READ_EN only) {overflow,full,empty,5'b0,count[7:0]}
// BEHAVIOUR
//  - Reset (rst=1 at edge): FIFO pointers/count=0, OP=8'h00, op_valid=0, full=0,
//    overflow=0, gap counter=0, FSM=IDLE. Reset mid-operation discards all entries and
//    any byte being presented; no handshake completes in a reset cycle.
//  - Push: MW=1 && add_out==PORT_ADDR at an edge writes data_out at tail.
//  - Full: push with count==DEPTH and no pop same edge -> byte dropped, overflow<=1,
//    FIFO unchanged. Push and pop same edge while full -> both succeed, count unchanged.
//  - Pointers log2(DEPTH) bits, wrap modulo DEPTH; count log2(DEPTH)+1 bits.
//  - FSM states:
//    IDLE: op_valid=0. If count>0: OP<=head, pop, op_valid<=1, ->SHOW.
//          A push into an empty FIFO at edge N is presented after edge N+1 (2-edge latency).
//    SHOW: op_valid=1, OP stable. op_ready=1 at edge -> handshake done:
//          if GAP_CYCLES>0: op_valid<=0, gap<=GAP_CYCLES-1, ->GAP.
//          else if count>0: OP<=head, pop, stay SHOW (back-to-back, 1 byte/cycle).
//          else op_valid<=0, ->IDLE.
//          op_ready=0: hold OP/op_valid indefinitely.
//    GAP:  op_valid=0; gap decrements each edge; at gap==0 ->IDLE.
//  - Pushes accepted in every state; a push arriving the edge FSM pops an empty FIFO is
//    not bypassed (next-cycle load only).
//  - OP retains last presented value in IDLE/GAP (display persistence).
//  - full is registered from count; reflects state after each edge.
// CONFIGURATION
//  STATUS_READ_EN defined: status_out present, combinational from current state;
//    count field zero-extended to 8 bits. Store to STATUS_ADDR with data_out[0]=1
//    clears overflow (clear wins over a same-edge set). Store to STATUS_ADDR never
//    enters FIFO.
//  STATUS_READ_EN undefined: no status_out port; STATUS_ADDR unused; overflow clears
//    only on rst.
// TESTING
//  1 Reset then store 8'hA5 to 8'hFF at edge 0, op_ready=0 -> op_valid=1, OP=8'hA5
//    after edge 1, held 10 cycles; op_ready=1 -> op_valid=0 next edge, OP stays 8'hA5.
//  2 Store 8'h10 to 8'h40 (non-port) -> op_valid stays 0, count 0; OP stays 8'h00.
//  3 DEPTH=8, op_ready=0: 10 port stores 8'h01..8'h0A -> full=1 after 9th store
//    (8 queued + 1 presenting), 10th dropped, overflow=1; drain with op_ready=1 ->
//    OP sequence 01..09 on consecutive cycles, then IDLE.
//  4 Full FIFO, push 8'h77 same edge as handshake -> no overflow, 8'h77 emerges last.
//  5 GAP_CYCLES=3: two queued bytes, op_ready=1 -> op_valid low exactly 3+1 cycles
//    between bytes (GAP then IDLE reload).
//  6 rst asserted while SHOW with 4 entries -> next edge op_valid=0, count=0, OP=8'h00;
//    with STATUS_READ_EN, status_out=16'h2000; store 8'h01 to 8'hFE clears overflow.

Source files
------------

// File: rtl/io_port_ctrl_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : io_port_ctrl_if
//  Purpose  : CPU store snoop bus plus byte-output handshake for io_port_ctrl.
//             Optional status_out signal exists only when STATUS_READ_EN is set.
//  Revision : 1.0  initial release
// ============================================================================
interface io_port_ctrl_if;
    logic       MW;
    logic [7:0] add_out;
    logic [7:0] data_out;
    logic [7:0] OP;
    logic       op_valid;
    logic       op_ready;
    logic       full;
    logic       overflow;
`ifdef STATUS_READ_EN
    logic [15:0] status_out;
`endif

    // CPU and board-level consumer side
    modport master (
        output MW, add_out, data_out, op_ready,
`ifdef STATUS_READ_EN
        input  status_out,
`endif
        input  OP, op_valid, full, overflow
    );

    // Port controller side
    modport slave (
        input  MW, add_out, data_out, op_ready,
`ifdef STATUS_READ_EN
        output status_out,
`endif
        output OP, op_valid, full, overflow
    );
endinterface
`default_nettype wire

// File: rtl/io_port_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : io_port_ctrl
//  Purpose  : Memory-mapped output port; queues CPU stores to PORT_ADDR in a
//             FIFO and presents them one byte at a time on a valid/ready link.
//             Optional feature macro: STATUS_READ_EN (status readout/clear).
//  Revision : 1.0  initial release
// ============================================================================
module io_port_ctrl #(
    parameter logic [7:0] PORT_ADDR   = 8'hFF,
    parameter logic [7:0] STATUS_ADDR = 8'hFE,
    parameter int         DEPTH       = 8,
    parameter int         GAP_CYCLES  = 0
) (
    input  wire logic     clk,
    input  wire logic     rst,
    io_port_ctrl_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [CW-1:0] c_FULL_CNT  = CW'(DEPTH);
    localparam logic [7:0]    c_GAP_INIT  = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic          c_USE_GAP   = (GAP_CYCLES > 0);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_SHOW = 2'd1;
    localparam logic [1:0] c_GAP  = 2'd2;

    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [7:0]    r_op;
    logic          r_valid;
    logic          r_full;
    logic          r_ovf;
    logic [7:0]    r_gap;
    logic [1:0]    r_state;

    logic [1:0]    w_state_nxt;
    logic          w_pop;
    logic          w_valid_nxt;
    logic [7:0]    w_gap_nxt;
    logic          w_push_req;
    logic          w_push;
    logic          w_ovf_set;
    logic          w_ovf_clr;
    logic          w_nonempty;
    logic [CW-1:0] w_count_nxt;

    assign w_nonempty = (r_count != '0);

    // The status address always takes precedence, so it can never be queued
    assign w_push_req = bus.MW && (bus.add_out == PORT_ADDR) && (bus.add_out != STATUS_ADDR);
    assign w_push     = w_push_req && ((r_count != c_FULL_CNT) || w_pop);
    assign w_ovf_set  = w_push_req && (r_count == c_FULL_CNT) && !w_pop;

`ifdef STATUS_READ_EN
    assign w_ovf_clr = bus.MW && (bus.add_out == STATUS_ADDR) && bus.data_out[0];
    assign bus.status_out = {r_ovf, r_full, !w_nonempty, 5'b0, 8'(r_count)};
`else
    assign w_ovf_clr = 1'b0;
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: if (w_nonempty) w_state_nxt = c_SHOW;
            c_SHOW: begin
                if (bus.op_ready) begin
                    if (c_USE_GAP)       w_state_nxt = c_GAP;
                    else if (!w_nonempty) w_state_nxt = c_IDLE;
                end
            end
            c_GAP:   if (r_gap == 8'd0) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_pop       = 1'b0;
        w_valid_nxt = r_valid;
        w_gap_nxt   = r_gap;
        case (r_state)
            c_IDLE: begin
                w_pop       = w_nonempty;
                w_valid_nxt = w_nonempty;
            end
            c_SHOW: begin
                if (bus.op_ready) begin
                    if (c_USE_GAP) begin
                        w_valid_nxt = 1'b0;
                        w_gap_nxt   = c_GAP_INIT;
                    end else if (w_nonempty) begin
                        w_pop = 1'b1;
                    end else begin
                        w_valid_nxt = 1'b0;
                    end
                end
            end
            c_GAP: begin
                w_valid_nxt = 1'b0;
                if (r_gap != 8'd0) w_gap_nxt = r_gap - 8'd1;
            end
            default: w_valid_nxt = 1'b0;
        endcase
    end

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop)      w_count_nxt = r_count + 1'b1;
        else if (!w_push && w_pop) w_count_nxt = r_count - 1'b1;
    end

    // Storage has no reset; occupancy is defined solely by the pointers
    always_ff @(posedge clk) begin
        if (w_push && !rst) r_mem[r_tail] <= bus.data_out;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_op    <= 8'h00;
            r_valid <= 1'b0;
            r_full  <= 1'b0;
            r_ovf   <= 1'b0;
            r_gap   <= 8'd0;
        end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop) begin
                r_op   <= r_mem[r_head];
                r_head <= r_head + 1'b1;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_FULL_CNT);
            r_valid <= w_valid_nxt;
            r_gap   <= w_gap_nxt;
            if (w_ovf_clr)      r_ovf <= 1'b0;
            else if (w_ovf_set) r_ovf <= 1'b1;
        end
    end

    assign bus.OP       = r_op;
    assign bus.op_valid = r_valid;
    assign bus.full     = r_full;
    assign bus.overflow = r_ovf;

endmodule
`default_nettype wire
